// File: rtl/spi_cmd_ctrl.sv
// Core-clock command controller behind the SPI slave front-end: synchronises the
// slave's frame/command flags, executes register writes and serves read-back words.
module spi_cmd_ctrl #(
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] CHIP_ID    = 32'h571C_0501,
  parameter int          RD_TIMEOUT = 16,
  parameter bit          AUTO_INC   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [35:0]       spi_rx_word_i,
  input  logic              rx_done_i,
  input  logic              crc5_chk_i,
  input  logic [3:0]        spi_cmd4b_i,
  input  logic              spi_cmd4b_en_i,
  output logic [31:0]       spi_tx_word_o,
  output logic              tx_ready_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [31:0]       reg_wdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  input  logic [31:0]       reg_rdata_i,
  input  logic              reg_rvalid_i,
  input  logic [31:0]       stim_st_i,
  output logic [7:0]        crc_err_cnt_o,
  output logic              rd_err_o
);
  localparam logic [3:0] CMD_WR_ADDR = 4'b0001;
  localparam logic [3:0] CMD_WR_DATA = 4'b0010;
  localparam logic [3:0] CMD_RD_DATA = 4'b0100;
  localparam logic [3:0] CMD_CHIP_ID = 4'b0110;
  localparam logic [3:0] CMD_STIM_ST = 4'b0111;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_LOAD    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam int TMR_W = $clog2(RD_TIMEOUT) + 1;

  logic [2:0]       rxd_sync;
  logic [2:0]       cen_sync;
  logic [1:0]       crc_sync;
  logic             frame_ev;
  logic             cmd_ev;
  logic             release_ev;
  logic             crc_ok;
  logic [3:0]       frame_cmd;
  logic [31:0]      frame_data;
  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [31:0]      word;

  // [0],[1] are the synchroniser pair, [2] is the edge-detect history
  assign frame_ev   = rxd_sync[1] & ~rxd_sync[2];
  assign cmd_ev     = cen_sync[1] & ~cen_sync[2];
  assign release_ev = ~cen_sync[1] & cen_sync[2];
  assign crc_ok     = crc_sync[1];
  assign frame_cmd  = spi_rx_word_i[35:32];
  assign frame_data = spi_rx_word_i[31:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_sync <= '0;
      cen_sync <= '0;
      crc_sync <= '0;
    end else begin
      rxd_sync <= {rxd_sync[1:0], rx_done_i};
      cen_sync <= {cen_sync[1:0], spi_cmd4b_en_i};
      crc_sync <= {crc_sync[0], crc5_chk_i};
    end
  end

  // Frame path: writes, address updates and CRC error accounting
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_wr_o      <= 1'b0;
      reg_wdata_o   <= '0;
      reg_addr_o    <= '0;
      crc_err_cnt_o <= '0;
    end else begin
      reg_wr_o <= 1'b0;
      if (frame_ev && !crc_ok && crc_err_cnt_o != 8'hFF)
        crc_err_cnt_o <= crc_err_cnt_o + 8'd1;
      if (frame_ev && crc_ok && frame_cmd == CMD_WR_DATA) begin
        reg_wdata_o <= frame_data;
        reg_wr_o    <= 1'b1;
      end
      // the strobe cycle uses the current address; the increment lands right after it
      if (frame_ev && crc_ok && frame_cmd == CMD_WR_ADDR)
        reg_addr_o <= frame_data[ADDR_W-1:0];
      else if (AUTO_INC && (reg_wr_o || reg_rd_o))
        reg_addr_o <= reg_addr_o + ADDR_W'(1);
    end
  end

  // Read path: speculative service on the command nibble, before the CRC is known
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      timer         <= '0;
      word          <= '0;
      spi_tx_word_o <= '0;
      tx_ready_o    <= 1'b0;
      reg_rd_o      <= 1'b0;
      rd_err_o      <= 1'b0;
    end else begin
      reg_rd_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_ev) begin
            case (spi_cmd4b_i)
              CMD_RD_DATA: begin
                state    <= ST_RD_REQ;
                reg_rd_o <= 1'b1;
              end
              CMD_CHIP_ID: begin
                word  <= CHIP_ID;
                state <= ST_LOAD;
              end
              CMD_STIM_ST: begin
                word  <= stim_st_i;
                state <= ST_LOAD;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_RD_REQ: begin
          timer <= '0;
          state <= release_ev ? ST_IDLE : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else if (reg_rvalid_i) begin
            word  <= reg_rdata_i;
            state <= ST_LOAD;
          end else if (timer == TMR_W'(RD_TIMEOUT - 1)) begin
            word     <= 32'hDEAD_DEAD;
            rd_err_o <= 1'b1;
            state    <= ST_LOAD;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_LOAD: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else begin
            spi_tx_word_o <= word;
            state         <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (release_ev) begin
            state      <= ST_IDLE;
            tx_ready_o <= 1'b0;
          end else begin
            tx_ready_o <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl: write path, read path, fixed words, CRC errors,
// read timeout, CS abort and mid-operation reset.
module tb_spi_cmd_ctrl;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [35:0] spi_rx_word_i;
  logic        rx_done_i;
  logic        crc5_chk_i;
  logic [3:0]  spi_cmd4b_i;
  logic        spi_cmd4b_en_i;
  logic [31:0] spi_tx_word_o;
  logic        tx_ready_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wr_o;
  logic        reg_rd_o;
  logic [31:0] reg_rdata_i;
  logic        reg_rvalid_i;
  logic [31:0] stim_st_i;
  logic [7:0]  crc_err_cnt_o;
  logic        rd_err_o;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [7:0]  wr_addr_seen;
  logic [31:0] wr_data_seen;
  logic [7:0]  rd_addr_seen;

  spi_cmd_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .spi_rx_word_i(spi_rx_word_i), .rx_done_i(rx_done_i),
    .crc5_chk_i(crc5_chk_i), .spi_cmd4b_i(spi_cmd4b_i), .spi_cmd4b_en_i(spi_cmd4b_en_i),
    .spi_tx_word_o(spi_tx_word_o), .tx_ready_o(tx_ready_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o),
    .reg_rdata_i(reg_rdata_i), .reg_rvalid_i(reg_rvalid_i), .stim_st_i(stim_st_i),
    .crc_err_cnt_o(crc_err_cnt_o), .rd_err_o(rd_err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr_o) begin
      wr_cnt = wr_cnt + 1;
      wr_addr_seen = reg_addr_o;
      wr_data_seen = reg_wdata_o;
    end
    if (reg_rd_o) begin
      rd_cnt = rd_cnt + 1;
      rd_addr_seen = reg_addr_o;
    end
  end

  task automatic send_frame(input logic [3:0] cmd, input logic [31:0] data, input logic crc);
    @(negedge clk);
    spi_rx_word_i = {cmd, data};
    crc5_chk_i = crc;
    rx_done_i = 1'b1;
    repeat (6) @(negedge clk);
    rx_done_i = 1'b0;
    crc5_chk_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cmd_release();
    @(negedge clk);
    spi_cmd4b_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({spi_tx_word_o, tx_ready_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, crc_err_cnt_o, rd_err_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got tx=%h rdy=%b addr=%h wd=%h wr=%b rd=%b cnt=%h err=%b, expected all 0",
               spi_tx_word_o, tx_ready_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, crc_err_cnt_o, rd_err_o);
    end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    send_frame(4'b0001, 32'h0000_0012, 1'b1);
    tests++;
    if (reg_addr_o !== 8'h12) begin fails++; $display("FAIL wr_addr: got %h expected 12", reg_addr_o); end
    send_frame(4'b0010, 32'hCAFE_F00D, 1'b1);
    tests++;
    if (wr_cnt !== 1) begin fails++; $display("FAIL wr_count: got %0d expected 1", wr_cnt); end
    tests++;
    if (wr_addr_seen !== 8'h12) begin fails++; $display("FAIL wr_strobe_addr: got %h expected 12", wr_addr_seen); end
    tests++;
    if (wr_data_seen !== 32'hCAFE_F00D) begin fails++; $display("FAIL wr_data: got %h expected cafef00d", wr_data_seen); end
    tests++;
    if (reg_addr_o !== 8'h13) begin fails++; $display("FAIL wr_autoinc: got %h expected 13", reg_addr_o); end
  endtask

  task automatic test_read();
    bit found = 0;
    @(negedge clk);
    spi_cmd4b_i = 4'b0100;
    spi_cmd4b_en_i = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (reg_rd_o) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rd_strobe: got none expected reg_rd_o within 10 cycles"); end
    tests++;
    if (reg_addr_o !== 8'h13) begin fails++; $display("FAIL rd_addr: got %h expected 13", reg_addr_o); end
    repeat (3) @(negedge clk);
    reg_rdata_i = 32'h0BAD_C0DE;
    reg_rvalid_i = 1'b1;
    @(negedge clk);
    reg_rvalid_i = 1'b0;
    reg_rdata_i = 32'h0;
    @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b0 || spi_tx_word_o !== 32'h0BAD_C0DE) begin
      fails++; $display("FAIL rd_load: got rdy=%b tx=%h expected rdy=0 tx=0badc0de", tx_ready_o, spi_tx_word_o);
    end
    @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL rd_ready: got %b expected 1", tx_ready_o); end
    repeat (5) @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL rd_ready_hold: got %b expected 1", tx_ready_o); end
    cmd_release();
    repeat (3) @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b0 || spi_tx_word_o !== 32'h0BAD_C0DE) begin
      fails++; $display("FAIL rd_release: got rdy=%b tx=%h expected rdy=0 tx=0badc0de", tx_ready_o, spi_tx_word_o);
    end
    tests++;
    if (rd_cnt !== 1 || rd_addr_seen !== 8'h13 || reg_addr_o !== 8'h14) begin
      fails++; $display("FAIL rd_count_addr: got cnt=%0d at=%h addr=%h expected cnt=1 at=13 addr=14", rd_cnt, rd_addr_seen, reg_addr_o);
    end
  endtask

  task automatic test_chip_id();
    @(negedge clk);
    spi_cmd4b_i = 4'b0110;
    spi_cmd4b_en_i = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b0 || spi_tx_word_o !== 32'h571C_0501) begin
      fails++; $display("FAIL id_word: got rdy=%b tx=%h expected rdy=0 tx=571c0501", tx_ready_o, spi_tx_word_o);
    end
    @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL id_latency: got rdy=%b expected 1", tx_ready_o); end
    send_frame(4'b0110, 32'h0, 1'b1);
    tests++;
    if (rd_cnt !== 1 || wr_cnt !== 1 || tx_ready_o !== 1'b1) begin
      fails++; $display("FAIL id_no_bus: got rd=%0d wr=%0d rdy=%b expected rd=1 wr=1 rdy=1", rd_cnt, wr_cnt, tx_ready_o);
    end
    cmd_release();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stim_st();
    @(negedge clk);
    stim_st_i = 32'h1234_ABCD;
    spi_cmd4b_i = 4'b0111;
    spi_cmd4b_en_i = 1'b1;
    repeat (3) @(negedge clk);
    stim_st_i = 32'h9999_9999;
    @(negedge clk);
    tests++;
    if (spi_tx_word_o !== 32'h1234_ABCD) begin fails++; $display("FAIL stim_word: got %h expected 1234abcd", spi_tx_word_o); end
    @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b1 || rd_cnt !== 1) begin
      fails++; $display("FAIL stim_ready: got rdy=%b rd=%0d expected rdy=1 rd=1", tx_ready_o, rd_cnt);
    end
    cmd_release();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_crc_err();
    send_frame(4'b0010, 32'h1111_1111, 1'b0);
    tests++;
    if (crc_err_cnt_o !== 8'd1) begin fails++; $display("FAIL crc_cnt_one: got %h expected 01", crc_err_cnt_o); end
    for (int i = 0; i < 299; i++) send_frame(4'b0010, 32'h2222_0000 + i, 1'b0);
    tests++;
    if (crc_err_cnt_o !== 8'hFF) begin fails++; $display("FAIL crc_cnt_sat: got %h expected ff", crc_err_cnt_o); end
    tests++;
    if (wr_cnt !== 1 || reg_addr_o !== 8'h14) begin
      fails++; $display("FAIL crc_no_write: got wr=%0d addr=%h expected wr=1 addr=14", wr_cnt, reg_addr_o);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    spi_cmd4b_i = 4'b0100;
    spi_cmd4b_en_i = 1'b1;
    repeat (19) @(negedge clk);
    tests++;
    if (rd_err_o !== 1'b0 || tx_ready_o !== 1'b0) begin
      fails++; $display("FAIL to_early: got err=%b rdy=%b expected err=0 rdy=0", rd_err_o, tx_ready_o);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (spi_tx_word_o !== 32'hDEAD_DEAD || rd_err_o !== 1'b1 || tx_ready_o !== 1'b0) begin
      fails++; $display("FAIL to_word: got tx=%h err=%b rdy=%b expected tx=deaddead err=1 rdy=0", spi_tx_word_o, rd_err_o, tx_ready_o);
    end
    @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b1) begin fails++; $display("FAIL to_ready: got %b expected 1", tx_ready_o); end
    reg_rdata_i = 32'h5555_5555;
    reg_rvalid_i = 1'b1;
    @(negedge clk);
    reg_rvalid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (spi_tx_word_o !== 32'hDEAD_DEAD || tx_ready_o !== 1'b1) begin
      fails++; $display("FAIL to_late_rvalid: got tx=%h rdy=%b expected tx=deaddead rdy=1", spi_tx_word_o, tx_ready_o);
    end
    cmd_release();
    repeat (3) @(negedge clk);
    tests++;
    if (reg_addr_o !== 8'h15 || rd_cnt !== 2) begin
      fails++; $display("FAIL to_addr: got addr=%h rd=%0d expected addr=15 rd=2", reg_addr_o, rd_cnt);
    end
  endtask

  task automatic test_abort_reset();
    bit got_ready = 0;
    @(negedge clk);
    spi_cmd4b_i = 4'b0100;
    spi_cmd4b_en_i = 1'b1;
    repeat (5) @(negedge clk);
    spi_cmd4b_en_i = 1'b0;
    repeat (4) @(negedge clk);
    reg_rdata_i = 32'h7777_7777;
    reg_rvalid_i = 1'b1;
    @(negedge clk);
    reg_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx_ready_o !== 1'b0 || spi_tx_word_o !== 32'hDEAD_DEAD) begin
      fails++; $display("FAIL abort_idle: got rdy=%b tx=%h expected rdy=0 tx=deaddead", tx_ready_o, spi_tx_word_o);
    end
    tests++;
    if (reg_addr_o !== 8'h16 || rd_cnt !== 3) begin
      fails++; $display("FAIL abort_addr: got addr=%h rd=%0d expected addr=16 rd=3", reg_addr_o, rd_cnt);
    end
    spi_cmd4b_i = 4'b0110;
    spi_cmd4b_en_i = 1'b1;
    for (int i = 0; i < 10 && !got_ready; i++) begin
      @(negedge clk);
      if (tx_ready_o) got_ready = 1;
    end
    tests++;
    if (!got_ready) begin fails++; $display("FAIL hold_reached: got rdy=0 expected 1 within 10 cycles"); end
    rst_i = 1'b1;
    spi_cmd4b_en_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    tests++;
    if ({spi_tx_word_o, tx_ready_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, crc_err_cnt_o, rd_err_o} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs: got tx=%h rdy=%b addr=%h wd=%h wr=%b rd=%b cnt=%h err=%b, expected all 0",
               spi_tx_word_o, tx_ready_o, reg_addr_o, reg_wdata_o, reg_wr_o, reg_rd_o, crc_err_cnt_o, rd_err_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (reg_wr_o !== 1'b0 || reg_rd_o !== 1'b0 || tx_ready_o !== 1'b0) begin
        fails++; $display("FAIL post_rst_quiet: got wr=%b rd=%b rdy=%b expected all 0", reg_wr_o, reg_rd_o, tx_ready_o);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    spi_rx_word_i = '0;
    rx_done_i = 1'b0;
    crc5_chk_i = 1'b0;
    spi_cmd4b_i = '0;
    spi_cmd4b_en_i = 1'b0;
    reg_rdata_i = '0;
    reg_rvalid_i = 1'b0;
    stim_st_i = '0;
    test_reset();
    test_write();
    test_read();
    test_chip_id();
    test_stim_st();
    test_crc_err();
    test_timeout();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
